// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Imported by the nibble corrector and the converter top.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [3:0] BCD_BLANK       = 4'hF;
  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

  // Elaboration-time 10^n, used as the exclusive upper limit of the input range.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational shift-and-add-3 nibble corrector: values of 5 or more get +3
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  assign o_nibble = (i_nibble >= BCD_ADD3_THRESH) ? i_nibble + 4'd3 : i_nibble;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 step per clock,
// registered packed-BCD result, blank code plus overflow flag for out-of-range input.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int NUM_WIDTH = 13,
  parameter int DIGITS    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [NUM_WIDTH-1:0]  i_number,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_digits,
  output logic                  o_overflow
);

  localparam int SR_W  = 4 * DIGITS + NUM_WIDTH;
  localparam int CNT_W = $clog2(NUM_WIDTH + 1);
  localparam longint unsigned LIMIT = pow10(DIGITS);

  state_t              r_state;
  logic [SR_W-1:0]     r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [4*DIGITS-1:0] r_digits;
  logic                r_overflow;

  logic [SR_W-1:0]     w_corr;
  logic [SR_W-1:0]     w_next;
  logic                w_in_range;

  assign w_in_range = ({1'b0, i_number} < LIMIT[NUM_WIDTH:0]);

  // BCD field sits above the binary field; each nibble is corrected before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nibble (r_shift[NUM_WIDTH + 4*g +: 4]),
      .o_nibble (w_corr [NUM_WIDTH + 4*g +: 4])
    );
  end

  assign w_corr[NUM_WIDTH-1:0] = r_shift[NUM_WIDTH-1:0];
  assign w_next                = {w_corr[SR_W-2:0], 1'b0};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the shift register is datapath, but it is reset anyway so a
      // post-reset state is fully deterministic; it is small enough not to matter.
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_digits   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            if (w_in_range) begin
              r_shift <= {{(4*DIGITS){1'b0}}, i_number};
              r_cnt   <= CNT_W'(NUM_WIDTH);
              r_state <= CONVERT;
            end else begin
              r_digits   <= {DIGITS{BCD_BLANK}};
              r_overflow <= 1'b1;
              r_state    <= DONE;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CONVERT: begin
          r_shift <= w_next;
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_digits   <= w_next[SR_W-1 -: 4*DIGITS];
            r_overflow <= 1'b0;
            r_state    <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state == CONVERT);
  assign o_done     = (r_state == DONE);
  assign o_digits   = r_digits;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: default 13-bit instance plus a 14-bit instance so the
// out-of-range (>= 10000) and 9999 cases are representable.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [13:0] number;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [15:0] dig_a, dig_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq u_dut_a (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (start_a), .i_number (number[12:0]),
    .o_busy (busy_a), .o_done (done_a), .o_digits (dig_a), .o_overflow (ovf_a)
  );

  bin_to_bcd_seq #(.NUM_WIDTH(14), .DIGITS(4)) u_dut_b (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (start_b), .i_number (number),
    .o_busy (busy_b), .o_done (done_b), .o_digits (dig_b), .o_overflow (ovf_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: decimal digits by plain division, blank when the value does not fit.
  function automatic logic [15:0] model_digits(input int n);
    logic [15:0] r;
    int p;
    if (n >= 10000) return 16'hFFFF;
    p = 1;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'((n / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic drive_start(input int sel, input logic v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  // One conversion: lat counts clock cycles from the cycle Start is driven until Done is seen.
  task automatic run_vec(input string name, input int sel, input int num,
                         input int chg_at, input int chg_val,
                         input logic [15:0] exp_dig, input logic exp_ovf);
    int lat, busy_n, nw;
    nw = (sel == 0) ? 13 : 14;
    @(negedge clk);
    number = 14'(num);
    drive_start(sel, 1'b1);
    lat = 0; busy_n = 0;
    @(negedge clk);
    drive_start(sel, 1'b0);
    lat = 1;
    while (!get_done(sel) && lat < 60) begin
      if (get_busy(sel)) busy_n++;
      if (lat == chg_at) number = 14'(chg_val);
      @(negedge clk);
      lat++;
    end
    check({name, " digits"}, (sel == 0) ? dig_a : dig_b, exp_dig);
    check({name, " overflow"}, (sel == 0) ? ovf_a : ovf_b, exp_ovf);
    check({name, " latency"}, lat, exp_ovf ? 1 : nw + 1);
    check({name, " busy cycles"}, busy_n, exp_ovf ? 0 : nw);
    @(negedge clk);
    check({name, " done one-cycle"}, get_done(sel), 1'b0);
  endtask

  typedef struct {
    string       name;
    int          sel;
    int          num;
    logic [15:0] dig;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t, t1, t2;
    logic [15:0] d1, d2;
    int seen_done;
    int rn;

    vecs[0] = '{"zero",     0,     0, 16'h0000, 1'b0};
    vecs[1] = '{"1234",     0,  1234, 16'h1234, 1'b0};
    vecs[2] = '{"8191",     0,  8191, 16'h8191, 1'b0};
    vecs[3] = '{"9999",     1,  9999, 16'h9999, 1'b0};
    vecs[4] = '{"10000",    1, 10000, 16'hFFFF, 1'b1};
    vecs[5] = '{"42 after", 1,    42, 16'h0042, 1'b0};
    vecs[6] = '{"16383",    1, 16383, 16'hFFFF, 1'b1};
    vecs[7] = '{"42 narrow",0,    42, 16'h0042, 1'b0};

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; number = '0;
    #12;
    check("reset digits", dig_a, 16'h0000);
    check("reset flags", {busy_a, done_a, ovf_a, busy_b, done_b, ovf_b}, 6'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_vec(vecs[i].name, vecs[i].sel, vecs[i].num, 0, 0, vecs[i].dig, vecs[i].ovf);

    // Start held high: busy-time Start ignored, second accept happens in DONE.
    @(negedge clk);
    number = 14'd5; start_a = 1'b1;
    t = 0; t1 = -1; t2 = -1; d1 = '0; d2 = '0;
    while (t2 < 0 && t < 60) begin
      @(negedge clk);
      t++;
      if (t == 1) number = 14'd17;
      if (done_a) begin
        if (t1 < 0) begin t1 = t; d1 = dig_a; end
        else begin t2 = t; d2 = dig_a; start_a = 1'b0; end
      end
    end
    check("b2b first time", t1, 14);
    check("b2b first digits", d1, 16'h0005);
    check("b2b second time", t2, 28);
    check("b2b second digits", d2, 16'h0017);
    @(negedge clk);

    // Reset asserted mid-conversion of 777 aborts it asynchronously.
    number = 14'd777; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort outputs", {dig_a, busy_a, done_a, ovf_a}, 19'h0);
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_a) seen_done++;
    end
    rst_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (done_a) seen_done++;
    end
    check("abort no done", seen_done, 0);
    run_vec("777 after reset", 0, 777, 0, 0, 16'h0777, 1'b0);

    run_vec("input change", 1, 300, 3, 9000, 16'h0300, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rn = int'($urandom_range(0, 8191));
      run_vec("rand narrow", 0, rn, 0, 0, model_digits(rn), 1'b0);
      rn = int'($urandom_range(0, 16383));
      run_vec("rand wide", 1, rn, 0, 0, model_digits(rn), rn >= 10000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
